firebird7_in_gate1_tessent_data_tdr_w19: RTL

// IJTAG test data register that drives the control side of the gate1 19-bit data mux.
// - Provides the mux select bit and the 19-bit IJTAG data word, both loaded by scan.
// - Captures the functional data bus so it can be observed through the scan path.
// - Sits on the gate1 IJTAG network, between the SIB-controlled scan segment and the mux.
//

---
 rtl/firebird7_in_gate1_tessent_data_tdr_w19.sv | 85 ++++++++
 1 files changed

// File: rtl/firebird7_in_gate1_tessent_data_tdr_w19.sv
// IJTAG data TDR for the gate1 19-bit mux: scan-loaded select + data word, captures the functional bus.
// Optional shift-length checking is built when FIREBIRD7_TDR_SHIFT_CHECK_EN is defined.
module firebird7_in_gate1_tessent_data_tdr_w19 #(
    parameter int unsigned      WIDTH      = 19,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
`ifdef FIREBIRD7_TDR_SHIFT_CHECK_EN
    output logic             shift_err,
`endif
    output logic [WIDTH-1:0] ijtag_data_out
);

    logic [WIDTH:0] shift_reg;
    logic           update_ok;

    assign ijtag_so = shift_reg[0];

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            shift_reg <= '0;
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                shift_reg <= {ijtag_select, functional_data_in};
            end else if (ijtag_se) begin
                shift_reg <= {ijtag_si, shift_reg[WIDTH:1]};
            end
        end
    end

`ifdef FIREBIRD7_TDR_SHIFT_CHECK_EN
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);

    logic [CNT_W-1:0] shift_cnt;

    // An update is only trusted after exactly one full register length of shifting.
    always_comb begin
        update_ok = (shift_cnt == CNT_W'(WIDTH + 1));
    end

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            shift_cnt <= '0;
            shift_err <= 1'b0;
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                shift_cnt <= '0;
            end else if (ijtag_se) begin
                if (shift_cnt != '1) begin
                    shift_cnt <= shift_cnt + 1'b1;
                end
            end else if (ijtag_ue) begin
                shift_cnt <= '0;
                if (!update_ok) begin
                    shift_err <= 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        update_ok = 1'b1;
    end
`endif

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            ijtag_select   <= 1'b0;
            ijtag_data_out <= RESET_DATA;
        end else if (ijtag_sel && !ijtag_ce && !ijtag_se && ijtag_ue && update_ok) begin
            ijtag_select   <= shift_reg[WIDTH];
            ijtag_data_out <= shift_reg[WIDTH-1:0];
        end
    end

endmodule
